// File: rtl/dmem_port_arbiter_if.sv
// Core-side bundle of the data-memory arbiter: flattened per-port request buses plus returned read data and ack.
// Port j occupies bits [(j+1)*W-1 -: W] of each flattened bus.
interface dmem_port_arbiter_if #(
  parameter int core_count = 2,
  parameter int reg_width  = 12,
  parameter int addr_width = 12
);
  logic [core_count-1:0]            req;
  logic [core_count-1:0]            mem_write;
  logic [addr_width*core_count-1:0] address;
  logic [reg_width*core_count-1:0]  datain;
  logic [reg_width*core_count-1:0]  dataout;
  logic [core_count-1:0]            ack;

  modport master (
    output req,
    output mem_write,
    output address,
    output datain,
    input  dataout,
    input  ack
  );

  modport slave (
    input  req,
    input  mem_write,
    input  address,
    input  datain,
    output dataout,
    output ack
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter serialising per-core requests onto one synchronous RAM; 4 cycles per access, ports hold req until ack.
// Optional DMEM_ARB_STATS_EN adds a saturating conflict_count of IDLE cycles with two or more requests pending.
module dmem_port_arbiter #(
  parameter int core_count = 2,
  parameter int reg_width  = 12,
  parameter int addr_width = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  dmem_port_arbiter_if.slave    cpu,
  output logic [addr_width-1:0] ram_address,
  output logic [reg_width-1:0]  ram_datain,
  output logic                  ram_wren,
  input  logic [reg_width-1:0]  ram_q
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]           conflict_count
`endif
);

  localparam int IDX_W = (core_count > 1) ? $clog2(core_count) : 1;
  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  localparam logic [core_count-1:0] ACK_ONE = {{(core_count-1){1'b0}}, 1'b1};

  state_t                          state;
  idx_t                            last;
  idx_t                            gidx;
  idx_t                            rr_idx;
  logic                            rr_hit;
  logic                            op_wr;
  logic [core_count-1:0]           ack_q;
  logic [reg_width*core_count-1:0] dataout_q;

  // Port reached after stepping 'off' places past 'base', wrapping at core_count.
  function automatic idx_t rr_step(idx_t base, int off);
    int c;
    c = int'(base) + off;
    if (c >= core_count) c = c - core_count;
    return idx_t'(c);
  endfunction

  // Search starts one past the last grant, so the previous winner is checked last.
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    for (int i = 1; i <= core_count; i++) begin
      if (!rr_hit && cpu.req[rr_step(last, i)]) begin
        rr_hit = 1'b1;
        rr_idx = rr_step(last, i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last        <= idx_t'(core_count - 1);
      gidx        <= '0;
      op_wr       <= 1'b0;
      ack_q       <= '0;
      dataout_q   <= '0;
      ram_address <= '0;
      ram_datain  <= '0;
      ram_wren    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rr_hit) begin
            gidx        <= rr_idx;
            last        <= rr_idx;
            op_wr       <= cpu.mem_write[rr_idx];
            ram_address <= cpu.address[rr_idx*addr_width +: addr_width];
            ram_datain  <= cpu.datain[rr_idx*reg_width +: reg_width];
            ram_wren    <= cpu.mem_write[rr_idx];
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          // The write commits on this edge; the address stays up for the read return.
          ram_wren <= 1'b0;
          state    <= WAIT;
        end
        WAIT: begin
          if (!op_wr) begin
            dataout_q[gidx*reg_width +: reg_width] <= ram_q;
          end
          ack_q       <= ACK_ONE << gidx;
          ram_address <= '0;
          ram_datain  <= '0;
          state       <= ACK;
        end
        ACK: begin
          ack_q <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cpu.ack     = ack_q;
  assign cpu.dataout = dataout_q;

`ifdef DMEM_ARB_STATS_EN
  logic        multi_req;
  logic [15:0] conflict_q;

  always_comb begin
    int n;
    n = 0;
    for (int i = 0; i < core_count; i++) begin
      n = n + int'(cpu.req[i]);
    end
    multi_req = (n >= 2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_q <= '0;
    end else if (state == IDLE && multi_req && conflict_q != 16'hFFFF) begin
      conflict_q <= conflict_q + 16'd1;
    end
  end

  assign conflict_count = conflict_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: stimulus pushes expected acks/RAM writes, monitors pop and compare.
// A behavioural synchronous RAM (one-cycle read latency) sits behind the arbiter.
module tb_dmem_port_arbiter;
  localparam int NC = 2;
  localparam int RW = 12;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.core_count(NC), .reg_width(RW), .addr_width(AW)) bus();

  logic [AW-1:0] ram_address;
  logic [RW-1:0] ram_datain;
  logic [RW-1:0] ram_q;
  logic          ram_wren;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]   conflict_count;
`endif

  dmem_port_arbiter #(.core_count(NC), .reg_width(RW), .addr_width(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu         (bus),
    .ram_address (ram_address),
    .ram_datain  (ram_datain),
    .ram_wren    (ram_wren),
    .ram_q       (ram_q)
`ifdef DMEM_ARB_STATS_EN
    ,
    .conflict_count (conflict_count)
`endif
  );

  logic [RW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    ram_q <= mem[ram_address];
    if (ram_wren) mem[ram_address] = ram_datain;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  typedef struct { int port; bit rd; logic [RW-1:0] data; int cyc; } ack_exp_t;
  typedef struct { logic [AW-1:0] addr; logic [RW-1:0] data; int cyc; } wr_exp_t;
  ack_exp_t ackq[$];
  wr_exp_t  wrq[$];
  logic [NC*RW-1:0] shadow = '0;

  task automatic exp_ack(int p, bit rd, logic [RW-1:0] d, int c);
    ack_exp_t e;
    e.port = p; e.rd = rd; e.data = d; e.cyc = c;
    ackq.push_back(e);
  endtask

  task automatic exp_wr(logic [AW-1:0] a, logic [RW-1:0] d, int c);
    wr_exp_t e;
    e.addr = a; e.data = d; e.cyc = c;
    wrq.push_back(e);
  endtask

  always @(negedge clk) begin : ack_mon
    ack_exp_t e;
    if (!reset && bus.ack != '0) begin
      if (ackq.size() == 0) begin
        chk("ack_unexpected", 32'(bus.ack), 0);
      end else begin
        e = ackq.pop_front();
        chk("ack_vec", 32'(bus.ack), 32'(1) << e.port);
        chk("ack_cycle", cyc, e.cyc);
        if (e.rd) shadow[e.port*RW +: RW] = e.data;
        chk("dataout", 32'(bus.dataout), 32'(shadow));
        chk("ram_bus_in_ack", 32'({ram_wren, ram_address, ram_datain}), 0);
      end
    end
  end

  always @(negedge clk) begin : wr_mon
    wr_exp_t e;
    if (!reset && ram_wren) begin
      if (wrq.size() == 0) begin
        chk("ram_wr_unexpected", 32'({ram_address, ram_datain}), 0);
      end else begin
        e = wrq.pop_front();
        chk("ram_wr_addr", 32'(ram_address), 32'(e.addr));
        chk("ram_wr_data", 32'(ram_datain), 32'(e.data));
        chk("ram_wr_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(int p, bit wr, logic [AW-1:0] a, logic [RW-1:0] d);
    bus.req[p]                = 1'b1;
    bus.mem_write[p]          = wr;
    bus.address[p*AW +: AW]   = a;
    bus.datain[p*RW +: RW]    = d;
  endtask

  task automatic wait_ack(int p);
    int n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (bus.ack[p]) break;
      n++;
    end
    if (n >= 40) chk("ack_timeout", 32'(bus.ack[p]), 1);
    tick();
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.req = '0;
    tick();
    tick();
    reset  = 1'b0;
    shadow = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[12'h005] = 12'h3A7;
    mem[12'h006] = 12'h5C1;
    bus.req = '0; bus.mem_write = '0; bus.address = '0; bus.datain = '0;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_dataout", 32'(bus.dataout), 0);
    chk("rst_ram_wren", 32'(ram_wren), 0);
    chk("rst_ram_address", 32'(ram_address), 0);
    chk("rst_ram_datain", 32'(ram_datain), 0);
`ifdef DMEM_ARB_STATS_EN
    chk("rst_conflict", 32'(conflict_count), 0);
`endif
    tick();

    // Simultaneous requests straight after reset: port 0 first, port 1 four cycles later
    c = cyc;
    set_port(0, 1'b0, 12'h005, 12'h000);
    set_port(1, 1'b0, 12'h006, 12'h000);
    exp_ack(0, 1'b1, 12'h3A7, c + 3);
    exp_ack(1, 1'b1, 12'h5C1, c + 7);
    wait_ack(0); bus.req[0] = 1'b0;
    wait_ack(1); bus.req[1] = 1'b0;
`ifdef DMEM_ARB_STATS_EN
    chk("conflict_first", 32'(conflict_count), 1);
`endif

    // Held requests alternate 0,1,0,1
    c = cyc;
    set_port(0, 1'b0, 12'h005, 12'h000);
    set_port(1, 1'b0, 12'h006, 12'h000);
    exp_ack(0, 1'b1, 12'h3A7, c + 3);
    exp_ack(1, 1'b1, 12'h5C1, c + 7);
    exp_ack(0, 1'b1, 12'h3A7, c + 11);
    exp_ack(1, 1'b1, 12'h5C1, c + 15);
    wait_ack(0); wait_ack(1); wait_ack(0); wait_ack(1);
    bus.req = '0;
`ifdef DMEM_ARB_STATS_EN
    chk("conflict_alt", 32'(conflict_count), 5);
`endif

    // Single read from a fresh reset, with the RAM address checked during ISSUE and WAIT
    do_reset();
    c = cyc;
    set_port(0, 1'b0, 12'h005, 12'h000);
    exp_ack(0, 1'b1, 12'h3A7, c + 3);
    tick();
    @(negedge clk);
    chk("rd_issue_addr", 32'(ram_address), 32'h005);
    chk("rd_issue_wren", 32'(ram_wren), 0);
    tick();
    @(negedge clk);
    chk("rd_wait_addr", 32'(ram_address), 32'h005);
    wait_ack(0); bus.req[0] = 1'b0;

    // Port 1 write then read back
    c = cyc;
    set_port(1, 1'b1, 12'h0FF, 12'hABC);
    exp_wr(12'h0FF, 12'hABC, c + 1);
    exp_ack(1, 1'b0, 12'h000, c + 3);
    wait_ack(1); bus.req[1] = 1'b0;
    c = cyc;
    set_port(1, 1'b0, 12'h0FF, 12'h000);
    exp_ack(1, 1'b1, 12'hABC, c + 3);
    wait_ack(1); bus.req[1] = 1'b0;

    // Same-address writes: port 0 granted first (last = 1), port 1 data survives
    c = cyc;
    set_port(0, 1'b1, 12'h010, 12'h111);
    set_port(1, 1'b1, 12'h010, 12'h222);
    exp_wr(12'h010, 12'h111, c + 1);
    exp_wr(12'h010, 12'h222, c + 5);
    exp_ack(0, 1'b0, 12'h000, c + 3);
    exp_ack(1, 1'b0, 12'h000, c + 7);
    wait_ack(0); bus.req[0] = 1'b0;
    wait_ack(1); bus.req[1] = 1'b0;
    c = cyc;
    set_port(0, 1'b0, 12'h010, 12'h000);
    exp_ack(0, 1'b1, 12'h222, c + 3);
    wait_ack(0); bus.req[0] = 1'b0;

    // Idle stability: monitors flag any stray ack or write
    for (int i = 0; i < 20; i++) tick();
    @(negedge clk);
    chk("idle_dataout", 32'(bus.dataout), 32'({12'hABC, 12'h222}));
`ifdef DMEM_ARB_STATS_EN
    chk("idle_conflict", 32'(conflict_count), 1);
`endif
    tick();

    // Reset during WAIT of a write: no ack, outputs cleared, write already in RAM
    c = cyc;
    set_port(0, 1'b1, 12'h020, 12'h7E5);
    exp_wr(12'h020, 12'h7E5, c + 1);
    tick();
    tick();
    reset = 1'b1;
    bus.req[0] = 1'b0;
    tick();
    @(negedge clk);
    chk("midrst_ack", 32'(bus.ack), 0);
    chk("midrst_dataout", 32'(bus.dataout), 0);
    chk("midrst_ram_wren", 32'(ram_wren), 0);
    chk("midrst_ram_address", 32'(ram_address), 0);
    shadow = '0;
    tick();
    reset = 1'b0;
    chk("midrst_ram_content", 32'(mem[12'h020]), 32'h7E5);
    c = cyc;
    set_port(1, 1'b0, 12'h020, 12'h000);
    exp_ack(1, 1'b1, 12'h7E5, c + 3);
    wait_ack(1); bus.req[1] = 1'b0;

    for (int i = 0; i < 5; i++) tick();
    chk("ackq_drained", 32'(ackq.size()), 0);
    chk("wrq_drained", 32'(wrq.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
